decode_stage: RTL

- Registered RV32I/RV64I instruction-decode pipeline stage for the core. It sits between fetch and execute, with valid/ready handshakes on both sides.
- Produces ALU operands, control flags and a JAL/branch target.
- Performs load-use interlock (bubble insertion), writeback bypass and flush.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/riscv_pkg.sv | 94 +++++++++
 rtl/imm_gen.sv | 24 ++
 rtl/decode_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: ALU operation enum, base opcodes,
// funct3 encodings for branches / memory sizes / ALU ops, the registered
// control bundle of the decode stage, and the funct3 -> ALU op mapping.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_opcode_t;

  // Base opcodes (instruction[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store size funct3
  localparam logic [2:0] F3_SIZE_B  = 3'b000;
  localparam logic [2:0] F3_SIZE_H  = 3'b001;
  localparam logic [2:0] F3_SIZE_W  = 3'b010;
  localparam logic [2:0] F3_SIZE_D  = 3'b011;
  localparam logic [2:0] F3_SIZE_BU = 3'b100;
  localparam logic [2:0] F3_SIZE_HU = 3'b101;
  localparam logic [2:0] F3_SIZE_WU = 3'b110;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Registered control part of the decoded instruction (data is XLEN-wide
  // and held separately in the stage).
  typedef struct packed {
    alu_opcode_t alu_opcode;
    logic        op1_is_rs1;
    logic        op2_is_rs2;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rd_id;
    logic        is_reg_write;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_size;
    logic        is_jump;
    logic        is_jalr;
    logic        is_branch;
    logic [2:0]  branch_type;
    logic        illegal;
  } decode_ctrl_t;

  // alt is instruction[30]; it selects SUB only for register-register ops,
  // but selects SRA for both OP and OP-IMM shifts.
  function automatic alu_opcode_t alu_op_from_funct3(input logic [2:0] f3,
                                                     input logic       alt,
                                                     input logic       is_reg);
    case (f3)
      F3_ADD:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediates from an
// instruction word and sign-extends them to XLEN.
//   instr  : instruction bits [31:7] (opcode bits carry no immediate)
//   imm_i/imm_s/imm_b/imm_u/imm_j : sign-extended immediates
module imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  always_comb begin
    imm_i = XLEN'($signed(instr[31:20]));
    imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I/RV64I decode pipeline stage between fetch and execute.
// Decodes the presented instruction into ALU operands, control flags and a
// JAL/branch target, registered with one cycle of latency. Handles load-use
// interlock (bubble insertion), same-cycle writeback bypass, flush, and a
// saturating count of load-use stall cycles.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_valid/o_ready         upstream handshake (i_pc, i_instruction)
//   o_rs1_id/o_rs2_id       register-file read addresses (combinational)
//   i_rs1_data/i_rs2_data   register-file read data
//   i_wb_*                  writeback port used for bypass
//   i_flush                 squash stage contents and drop input
//   o_valid/i_ready         downstream handshake (all other o_* outputs)
//   o_stall_count           saturating load-use stall-cycle counter
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ENABLE_WB_BYPASS = 1,
  parameter int unsigned STALL_CNT_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [31:0]            i_instruction,
  output logic [4:0]             o_rs1_id,
  output logic [4:0]             o_rs2_id,
  input  logic [XLEN-1:0]        i_rs1_data,
  input  logic [XLEN-1:0]        i_rs2_data,
  input  logic                   i_wb_reg_write,
  input  logic [4:0]             i_wb_rd_id,
  input  logic [XLEN-1:0]        i_wb_data,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [XLEN-1:0]        o_pc,
  output alu_opcode_t            o_alu_opcode,
  output logic [XLEN-1:0]        o_alu_op1,
  output logic [XLEN-1:0]        o_alu_op2,
  output logic                   o_op1_is_rs1,
  output logic                   o_op2_is_rs2,
  output logic [4:0]             o_rs1_id_q,
  output logic [4:0]             o_rs2_id_q,
  output logic [4:0]             o_rd_id,
  output logic                   o_is_reg_write,
  output logic                   o_is_load,
  output logic                   o_is_store,
  output logic [2:0]             o_mem_size,
  output logic                   o_is_jump,
  output logic                   o_is_jalr,
  output logic [XLEN-1:0]        o_jump_address,
  output logic                   o_is_branch,
  output logic [2:0]             o_branch_type,
  output logic [XLEN-1:0]        o_store_data,
  output logic [XLEN-1:0]        o_imm,
  output logic                   o_illegal,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  assign opcode = i_instruction[6:0];
  assign rd     = i_instruction[11:7];
  assign funct3 = i_instruction[14:12];
  assign rs1    = i_instruction[19:15];
  assign rs2    = i_instruction[24:20];

  assign o_rs1_id = rs1;
  assign o_rs2_id = rs2;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (i_instruction[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // Source operand values: x0 is forced to zero ahead of any bypass.
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = i_rs1_data;
    rs2_val = i_rs2_data;
    if (ENABLE_WB_BYPASS != 0 && i_wb_reg_write) begin
      if (i_wb_rd_id == rs1) rs1_val = i_wb_data;
      if (i_wb_rd_id == rs2) rs2_val = i_wb_data;
    end
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  // Control decode
  decode_ctrl_t    ctrl_d;
  logic [XLEN-1:0] op1_d, op2_d, jump_d, store_d, imm_d;
  logic            uses_rs1, uses_rs2;

  always_comb begin
    ctrl_d   = '0;
    op1_d    = '0;
    op2_d    = '0;
    jump_d   = '0;
    store_d  = '0;
    imm_d    = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    ctrl_d.alu_opcode = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ctrl_d.is_reg_write = 1'b1;
        ctrl_d.alu_opcode   = alu_op_from_funct3(funct3, i_instruction[30], 1'b1);
        op1_d = rs1_val;
        op2_d = rs2_val;
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        ctrl_d.is_reg_write = 1'b1;
        ctrl_d.alu_opcode   = alu_op_from_funct3(funct3, i_instruction[30], 1'b0);
        imm_d = imm_i;
        op1_d = rs1_val;
        op2_d = imm_i;
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        ctrl_d.is_reg_write = 1'b1;
        ctrl_d.is_load      = 1'b1;
        ctrl_d.mem_size     = funct3;
        imm_d = imm_i;
        op1_d = rs1_val;
        op2_d = imm_i;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ctrl_d.is_store = 1'b1;
        ctrl_d.mem_size = funct3;
        imm_d   = imm_s;
        op1_d   = rs1_val;
        op2_d   = imm_s;
        store_d = rs2_val;
      end
      OPC_LUI: begin
        ctrl_d.is_reg_write = 1'b1;
        imm_d = imm_u;
        op2_d = imm_u;
      end
      OPC_AUIPC: begin
        ctrl_d.is_reg_write = 1'b1;
        imm_d = imm_u;
        op1_d = i_pc;
        op2_d = imm_u;
      end
      OPC_JAL: begin
        ctrl_d.is_reg_write = 1'b1;
        ctrl_d.is_jump      = 1'b1;
        imm_d  = imm_j;
        op1_d  = i_pc;
        op2_d  = XLEN'(4);
        jump_d = i_pc + imm_j;
      end
      OPC_JALR: begin
        uses_rs1 = 1'b1;
        ctrl_d.is_reg_write = 1'b1;
        ctrl_d.is_jump      = 1'b1;
        ctrl_d.is_jalr      = 1'b1;
        imm_d = imm_i;
        op1_d = i_pc;
        op2_d = XLEN'(4);
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ctrl_d.is_branch   = 1'b1;
        ctrl_d.branch_type = funct3;
        ctrl_d.alu_opcode  = ALU_SUB;
        imm_d  = imm_b;
        op1_d  = rs1_val;
        op2_d  = rs2_val;
        jump_d = i_pc + imm_b;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    // Operands from a register are exactly the rs-sourced ALU inputs; store
    // and JALR read rs1/rs2 but do not route them to the ALU as such.
    ctrl_d.op1_is_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                        (opcode == OPC_LOAD) || (opcode == OPC_STORE) ||
                        (opcode == OPC_BRANCH);
    ctrl_d.op2_is_rs2 = (opcode == OPC_OP) || (opcode == OPC_BRANCH);
    ctrl_d.rs1_id = uses_rs1 ? rs1 : 5'd0;
    ctrl_d.rs2_id = uses_rs2 ? rs2 : 5'd0;
    ctrl_d.rd_id  = ctrl_d.is_reg_write ? rd : 5'd0;
  end

  // Pipeline register
  decode_ctrl_t           ctrl_q;
  logic                   valid_q;
  logic [XLEN-1:0]        pc_q, op1_q, op2_q, jump_q, store_q, imm_q;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   load_use;

  // Only IDs of sources actually used reach the comparison (ctrl_d.rsX_id).
  assign load_use = i_valid && valid_q && ctrl_q.is_load && (ctrl_q.rd_id != 5'd0) &&
                    (((ctrl_d.rs1_id != 5'd0) && (ctrl_d.rs1_id == ctrl_q.rd_id)) ||
                     ((ctrl_d.rs2_id != 5'd0) && (ctrl_d.rs2_id == ctrl_q.rd_id)));

  assign o_ready = i_flush || (!load_use && (!valid_q || i_ready));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      jump_q    <= '0;
      store_q   <= '0;
      imm_q     <= '0;
      stall_cnt <= '0;
    end else begin
      if (load_use && !i_flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (i_flush) begin
        valid_q <= 1'b0;
      end else if (!valid_q || i_ready) begin
        if (i_valid && !load_use) begin
          valid_q <= 1'b1;
          ctrl_q  <= ctrl_d;
          pc_q    <= i_pc;
          op1_q   <= op1_d;
          op2_q   <= op2_d;
          jump_q  <= jump_d;
          store_q <= store_d;
          imm_q   <= imm_d;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign o_valid        = valid_q;
  assign o_pc           = pc_q;
  assign o_alu_opcode   = ctrl_q.alu_opcode;
  assign o_alu_op1      = op1_q;
  assign o_alu_op2      = op2_q;
  assign o_op1_is_rs1   = ctrl_q.op1_is_rs1;
  assign o_op2_is_rs2   = ctrl_q.op2_is_rs2;
  assign o_rs1_id_q     = ctrl_q.rs1_id;
  assign o_rs2_id_q     = ctrl_q.rs2_id;
  assign o_rd_id        = ctrl_q.rd_id;
  assign o_is_reg_write = ctrl_q.is_reg_write;
  assign o_is_load      = ctrl_q.is_load;
  assign o_is_store     = ctrl_q.is_store;
  assign o_mem_size     = ctrl_q.mem_size;
  assign o_is_jump      = ctrl_q.is_jump;
  assign o_is_jalr      = ctrl_q.is_jalr;
  assign o_jump_address = jump_q;
  assign o_is_branch    = ctrl_q.is_branch;
  assign o_branch_type  = ctrl_q.branch_type;
  assign o_store_data   = store_q;
  assign o_imm          = imm_q;
  assign o_illegal      = ctrl_q.illegal;
  assign o_stall_count  = stall_cnt;

endmodule
